// File: rtl/cmac_array_if.sv
// ---------------------------------------------------------------------------
// cmac_array_if
// Bundles the job-control, input-beat and output-result signals of the
// multi-lane convolution MAC engine.
//   master : job issuer / data-weight fetch / write-back side
//   slave  : the cmac_array engine
// Signals:
//   start, op_num, relu_en, bias     job set-up, sampled together with start
//   in_valid, in_ready, data, weight input beat handshake (weight per lane)
//   out_valid, out_ready, result,    output handshake, per-lane result and
//   overflow                         saturation flags
//   busy                             engine is not idle
// Per-lane vectors pack lane i at [i*DATA_W +: DATA_W].
// ---------------------------------------------------------------------------
interface cmac_array_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
);
  logic                      start;
  logic [CNT_W-1:0]          op_num;
  logic                      relu_en;
  logic [LANES*DATA_W-1:0]   bias;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         data;
  logic [LANES*DATA_W-1:0]   weight;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   result;
  logic [LANES-1:0]          overflow;
  logic                      busy;

  modport master (
    output start, op_num, relu_en, bias, in_valid, data, weight, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  start, op_num, relu_en, bias, in_valid, data, weight, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/cmac_array.sv
// ---------------------------------------------------------------------------
// cmac_array
// Multi-lane fixed-point convolution MAC. One shared activation stream is
// multiplied by LANES weight streams; each lane accumulates op_num products,
// adds its bias, optionally applies ReLU and saturates to DATA_W bits.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any job in progress
//   bus    cmac_array_if slave modport (job set-up, input beats, results)
// Pipeline: beat accepted at edge t -> product registered at t ->
// accumulated at t+1 -> result/out_valid registered at t+2.
// ---------------------------------------------------------------------------
module cmac_array #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  cmac_array_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;

  // Saturation bounds expressed at accumulator width for signed compares.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_BIAS,
    S_OUT
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_relu;
  logic [LANES*DATA_W-1:0] r_bias;
  logic                    r_pvld;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;
  logic [LANES*DATA_W-1:0] r_result;
  logic [LANES-1:0]        r_ovf;

  logic                    w_start;
  logic                    w_accept;
  logic [LANES*DATA_W-1:0] w_result;
  logic [LANES-1:0]        w_sat;
  logic signed [DATA_W-1:0] w_data;

  // r_in_ready is high exactly while in S_MAC, so it doubles as the state
  // qualifier for beat acceptance.
  assign w_start  = (r_state == S_IDLE) && bus.start;
  assign w_accept = r_in_ready && bus.in_valid;
  assign w_data   = bus.data;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_relu      <= 1'b0;
      r_bias      <= '0;
      r_pvld      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_ovf       <= '0;
    end else begin
      // A product is only ever added once: the flag lives for one cycle
      // after each accepted beat, so in_valid gaps add nothing.
      r_pvld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt  <= bus.op_num;
            r_relu <= bus.relu_en;
            r_bias <= bus.bias;
            r_busy <= 1'b1;
            if (bus.op_num != '0) begin
              r_state    <= S_MAC;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= S_BIAS;
            end
          end
        end
        S_MAC: begin
          if (w_accept) begin
            r_pvld <= 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_BIAS;
        end
        S_BIAS: begin
          r_result    <= w_result;
          r_ovf       <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Per-lane datapath: multiply, accumulate, bias/shift/ReLU/saturate
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] w_wt;
      logic signed [DATA_W-1:0] w_bias;
      logic signed [PROD_W-1:0] r_prod;
      logic signed [ACC_W-1:0]  r_acc;
      logic signed [ACC_W-1:0]  w_sum;
      logic signed [ACC_W-1:0]  w_shift;
      logic signed [DATA_W-1:0] w_res;
      logic                     w_ovf;

      assign w_wt   = bus.weight[gi*DATA_W +: DATA_W];
      assign w_bias = r_bias[gi*DATA_W +: DATA_W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prod <= '0;
          r_acc  <= '0;
        end else begin
          if (w_accept) begin
            r_prod <= PROD_W'(w_data) * PROD_W'(w_wt);
          end
          if (w_start) begin
            r_acc <= '0;
          end else if (r_pvld) begin
            // Wraps modulo 2^ACC_W by construction.
            r_acc <= r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
          end
        end
      end

      // Bias is aligned to the product's Q(2*FRAC_W) scale before adding.
      assign w_sum   = r_acc + {{(ACC_W-DATA_W-FRAC_W){w_bias[DATA_W-1]}},
                                w_bias, {FRAC_W{1'b0}}};
      assign w_shift = w_sum >>> FRAC_W;

      always_comb begin
        w_res = w_shift[DATA_W-1:0];
        w_ovf = 1'b0;
        if (r_relu && w_shift[ACC_W-1]) begin
          w_res = '0;
        end else if (w_shift > SAT_MAX) begin
          w_res = RES_MAX;
          w_ovf = 1'b1;
        end else if (w_shift < SAT_MIN) begin
          w_res = RES_MIN;
          w_ovf = 1'b1;
        end
      end

      assign w_result[gi*DATA_W +: DATA_W] = w_res;
      assign w_sat[gi]                     = w_ovf;
    end
  endgenerate

endmodule

// File: tb/tb_cmac_array.sv
module tb_cmac_array;
  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cmac_array_if #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  cmac_array #(
    .LANES(LANES), .DATA_W(DATA_W), .FRAC_W(FRAC_W),
    .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] op;
    logic        relu;
    logic [63:0] bias;
    logic [15:0] data;
    logic [63:0] weight;
    bit          gaps;
    int          stall;
    bit          poke;
    logic [63:0] exp_res;
    logic [3:0]  exp_ovf;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  ovf;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   job_no = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] op, input logic relu,
                              input logic [63:0] bias, input logic [15:0] data,
                              input logic [63:0] weight, input bit gaps,
                              input int stall, input bit poke,
                              input logic [63:0] er, input logic [3:0] eo);
    vec_t v;
    v.op = op; v.relu = relu; v.bias = bias; v.data = data; v.weight = weight;
    v.gaps = gaps; v.stall = stall; v.poke = poke; v.exp_res = er; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic run_job(input vec_t v);
    exp_t e;
    int beats, guard, last_acc, start_edge, wcnt, extra, lat;
    e.res = v.exp_res;
    e.ovf = v.exp_ovf;
    sb.push_back(e);

    @(posedge clk); #1;
    bus.op_num    = v.op;
    bus.relu_en   = v.relu;
    bus.bias      = v.bias;
    bus.start     = 1'b1;
    bus.out_ready = (v.stall == 0);
    @(posedge clk); #1;
    start_edge = cyc;
    bus.start  = 1'b0;
    // Set-up inputs are only meaningful with start; scramble them afterwards.
    bus.op_num  = 32'hDEAD_BEEF;
    bus.relu_en = ~v.relu;
    bus.bias    = ~v.bias;
    chk("busy_after_start", 64'(bus.busy), 64'd1);

    beats = 0; guard = 0; last_acc = start_edge;
    while (beats < int'(v.op) && guard < 400) begin
      bus.in_valid = v.gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.data     = bus.in_valid ? v.data : 16'($urandom);
      bus.weight   = bus.in_valid ? v.weight : {$urandom, $urandom};
      bus.start    = v.poke && (beats == 1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        beats++;
        last_acc = cyc + 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.start = 1'b0;
    if (v.op != 0) chk("in_ready_fall", 64'(bus.in_ready), 64'd0);

    // Keep offering garbage beats: none may be accepted any more.
    bus.in_valid = 1'b1;
    bus.data     = 16'h1234;
    bus.weight   = 64'h1234_5678_9ABC_DEF0;
    extra = 0; wcnt = 0;
    @(negedge clk);
    while (!bus.out_valid && wcnt < 50) begin
      if (bus.in_valid && bus.in_ready) extra++;
      @(negedge clk);
      wcnt++;
    end
    bus.in_valid = 1'b0;
    chk("beats_accepted", 64'(beats + extra), 64'(v.op));

    if (!bus.out_valid) begin
      chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
      void'(sb.pop_front());
      return;
    end

    lat = (v.op != 0) ? (cyc - last_acc) : (cyc - start_edge);
    chk(v.op != 0 ? "latency_after_last_beat" : "latency_after_start",
        64'(lat), v.op != 0 ? 64'd2 : 64'd1);

    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk("result", bus.result, e.res);
    chk("overflow", 64'(bus.overflow), 64'(e.ovf));
    $display("job %0d op=%0d relu=%0d result=%h overflow=%b latency=%0d",
             job_no, v.op, v.relu, bus.result, bus.overflow, lat);
    job_no++;

    for (int k = 0; k < v.stall; k++) begin
      bus.start = v.poke && (k == 0);
      @(negedge clk);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_result", bus.result, e.res);
      chk("hold_overflow", 64'(bus.overflow), 64'(e.ovf));
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("busy_drop", 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_result"}, bus.result, 64'd0);
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op_num = '0; bus.relu_en = 1'b0; bus.bias = '0;
    bus.in_valid = 1'b0; bus.data = '0; bus.weight = '0; bus.out_ready = 1'b0;

    //            op relu bias                   data      weight {l3,l2,l1,l0}   gaps stall poke  expected {l3,l2,l1,l0}  ovf
    vecs[0] = mk(3, 0, 64'h0100_0100_0100_0100, 16'h0100, 64'h0000_0080_FF00_0200, 0, 0, 0, 64'h0100_0280_FE00_0700, 4'b0000);
    vecs[1] = mk(3, 1, 64'h0100_0100_0100_0100, 16'h0100, 64'h0000_0080_FF00_0200, 0, 1, 0, 64'h0100_0280_0000_0700, 4'b0000);
    vecs[2] = mk(4, 0, 64'h0,                   16'h7FFF, 64'h0000_0000_8001_7FFF, 0, 0, 0, 64'h0000_0000_8000_7FFF, 4'b0011);
    vecs[3] = mk(8, 0, 64'h0,                   16'h0100, 64'h7FFF_0300_FFF0_0010, 1, 5, 0, 64'h7FFF_1800_FF80_0080, 4'b1000);
    vecs[4] = mk(8, 0, 64'h0,                   16'h0100, 64'h7FFF_0300_FFF0_0010, 0, 0, 0, 64'h7FFF_1800_FF80_0080, 4'b1000);
    vecs[5] = mk(0, 0, 64'h7FFF_8000_0123_FF80, 16'h0000, 64'h0,                   0, 0, 0, 64'h7FFF_8000_0123_FF80, 4'b0000);
    vecs[6] = mk(0, 1, 64'h7FFF_8000_0123_FF80, 16'h0000, 64'h0,                   0, 2, 0, 64'h7FFF_0000_0123_0000, 4'b0000);
    vecs[7] = mk(1, 0, 64'h0,                   16'hFFFF, 64'hFFFF_0000_0080_0001, 0, 0, 0, 64'h0000_0000_FFFF_FFFF, 4'b0000);
    vecs[8] = mk(3, 0, 64'h0100_0100_0100_0100, 16'h0100, 64'h0000_0080_FF00_0200, 0, 3, 1, 64'h0100_0280_FE00_0700, 4'b0000);
    vecs[9] = mk(1, 0, 64'h0,                   16'h0100, 64'h0100_0100_0100_0100, 0, 0, 0, 64'h0100_0100_0100_0100, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("after_reset");

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i]);
    end

    // Abort a 5-beat job after two accepted beats.
    @(posedge clk); #1;
    bus.op_num = 32'd5; bus.relu_en = 1'b0; bus.bias = 64'h0200_0200_0200_0200;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.data     = 16'h0100;
    bus.weight   = 64'h0300_0300_0300_0300;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_in_ready_before_reset", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_job_reset");
    bus.in_valid = 1'b0;
    $display("job %0d aborted by reset after 2 beats", job_no);
    job_no++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no_output_after_abort", 64'(bus.out_valid), 64'd0);

    run_job(vecs[9]);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmac_array.md
# cmac_array

Parametrised multi-lane fixed-point convolution MAC engine, the successor to the single-lane floating-point convolution MAC. One shared input activation stream is multiplied by LANES independent weight streams, one per output channel. Each lane accumulates op_num products, adds a per-lane bias, optionally applies ReLU, and saturates. It sits between the convolution data/weight fetch logic and the output write-back path, with valid/ready handshakes on both sides.

## Interface
- LANES, 4, number of parallel output channels
- DATA_W, 16, signed width of data, weight, bias and result
- FRAC_W, 8, fractional bits of data/weight/bias/result (Q format)
- ACC_W, 40, signed accumulator width; ACC_W ≥ 2*DATA_W + 1
- CNT_W, 32, width of op_num
---
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse; only honoured in IDLE
- op_num  in  CNT_W  products per output; sampled with start
- relu_en  in  1  ReLU enable; sampled with start
- bias  in  LANES*DATA_W  per-lane bias, lane i at [i*DATA_W +: DATA_W]; sampled with start
- in_valid  in  1  data/weight beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- data  in  DATA_W  shared activation
- weight  in  LANES*DATA_W  per-lane weight, same packing as bias
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts when out_valid & out_ready
- result  out  LANES*DATA_W  per-lane output, same packing
- overflow  out  LANES  per-lane saturation flag, valid with result
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, MAC, DRAIN, BIAS, OUT.
- IDLE:
  - in_ready=0.
  - On start: latch op_num into counter, latch relu_en and bias, clear all accumulators and the product-valid flag.
  - Next state is MAC if op_num≠0, otherwise BIAS.
- MAC:
  - in_ready=1.
  - Each accepted beat registers LANES signed products data*weight[i] (2*DATA_W bits) and sets product-valid. The counter decrements.
  - Any registered product is added, sign-extended, into its lane accumulator on the next edge.
  - Accepting the beat when counter==1 moves to DRAIN.
- DRAIN: the last product is added into the accumulators; next state is BIAS.
- BIAS:
  - Each acc[i] + (sign-extended bias[i] << FRAC_W) is computed combinationally.
  - Each lane then:
    - arithmetic-shifts right by FRAC_W (floor);
    - forces negative values to 0 if relu_en;
    - saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - The result, and overflow[i]=1 for any lane that saturated, are registered. out_valid is set. Next state is OUT.
- OUT:
  - result, overflow and out_valid are held stable.
  - On out_valid & out_ready: out_valid←0, next state IDLE.
- Accumulators wrap modulo 2^ACC_W. Sizing ACC_W for the maximum op_num is the integrator's responsibility.
- start outside IDLE is ignored. Input values other than in_valid are don't-care while in_ready=0.
- Reset, including mid-job: asynchronous return to IDLE. The job is discarded and no result is produced.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, busy=0.
  - result=0, overflow=0.
  - Accumulators, counter and product-valid are 0.
- Start sampled at edge s: busy rises after s; in_ready rises after s (op_num≠0).
- Last beat accepted at edge t:
  - in_ready falls after t.
  - Accumulators are final at t+1.
  - result/out_valid are registered at t+2.
  - Fixed 2-cycle post-input latency.
- op_num=0: start at edge s gives out_valid after edge s+1, with result = saturated bias (ReLU applied if enabled).
- in_valid gaps stall the counter only; there is no throughput penalty beyond the gaps. Peak throughput is 1 beat/cycle.
- out_ready is not required to be high in advance. The earliest next start is sampled the cycle after the output handshake edge (IDLE for ≥1 cycle).
- in_ready does not depend combinationally on in_valid. out_valid does not depend combinationally on out_ready.

## Test plan
- Basic job, default parameters:
  - Stimulus: op_num=3, relu_en=0, bias all 0x0100; three beats of data=0x0100; weights lane0..3 = 0x0200, 0xFF00, 0x0080, 0x0000.
  - Required: result = 0x0700, 0xFE00, 0x0280, 0x0100; overflow=0; out_valid exactly 2 edges after the third accept.
- Same job with relu_en=1: lane1 = 0x0000; other lanes unchanged; overflow=0.
- Saturation:
  - Positive: data=0x7FFF, weight lane0=0x7FFF, op_num=4 → lane0 result=0x7FFF, overflow[0]=1.
  - Negative: weight lane1=0x8001 → lane1 result=0x8000, overflow[1]=1.
- Backpressure, op_num=8:
  - Stimulus: in_valid pseudo-random with gaps; out_ready held low 5 cycles after out_valid rises.
  - Required: sum matches the gap-free run; result and out_valid stable while stalled; exactly 8 beats accepted.
- Edge cases:
  - op_num=0 with bias lane0=0xFF80 → 0xFF80 (relu off) or 0x0000 (relu on), out_valid one edge after start.
  - start pulsed during MAC and during OUT → ignored, job result unchanged.
- Reset: rst_n low in the middle of MAC after 2 of 5 beats:
  - Required: all outputs return to their reset values immediately.
  - A following job with op_num=1, data=0x0100, weight=0x0100, bias=0 gives result 0x0100 on every lane, with no residue from the aborted job.
